jtpopeye_sdram_arb: RTL and testbench

- Shares the single SDRAM read port between two requesters:
  - the main CPU ROM fetch path (32 kB, byte-wide);
  - the OBJ graphics ROM fetch path (32-bit words).
- Sits between the main CPU/video blocks and the SDRAM controller.
- Sequences one read at a time with a toggle-request / fixed-latency protocol.
- Keeps a one-entry cache per requester so repeated addresses answer without an SDRAM access.

---
 rtl/jtpopeye_sdram_arb.sv | 147 ++++++++++++++
 tb/tb_jtpopeye_sdram_arb.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtpopeye_sdram_arb.sv
// Two-port SDRAM read arbiter for the Popeye core: main CPU ROM bytes and OBJ ROM words
// share one toggle-request / fixed-latency SDRAM read port, each requester with a one-entry cache.
module jtpopeye_sdram_arb #(
  parameter int unsigned LATENCY    = 4,
  parameter logic [21:0] OBJ_OFFSET = 22'h4000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        downloading,
  input  logic        loop_rst,
  input  logic        main_cs,
  input  logic [14:0] main_addr,
  output logic [7:0]  main_dout,
  output logic        main_ok,
  input  logic        obj_cs,
  input  logic [12:0] obj_addr,
  output logic [31:0] obj_dout,
  output logic        obj_ok,
  output logic        sdram_re,
  output logic [21:0] sdram_addr,
  input  logic [31:0] data_read
);

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;
  typedef enum logic {GRANT_MAIN, GRANT_OBJ} grant_t;

  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  state_t      state;
  grant_t      grant;
  grant_t      last_grant;
  grant_t      pick;
  logic [3:0]  cnt;

  logic        main_valid;
  logic [13:0] main_tag;
  logic [15:0] main_data;
  logic [13:0] main_req;
  logic        obj_valid;
  logic [12:0] obj_tag;
  logic [31:0] obj_data;
  logic [12:0] obj_req;

  logic [13:0] main_word;
  logic [21:0] main_sdram;
  logic [21:0] obj_sdram;
  logic        main_hit;
  logic        obj_hit;
  logic        main_pend;
  logic        obj_pend;
  logic        frozen;
  logic        fire;
  logic        fill;

  assign main_word  = main_addr[14:1];
  assign main_sdram = {8'd0, main_word};
  // Offset addition wraps modulo 2^22 on purpose.
  assign obj_sdram  = OBJ_OFFSET + {8'd0, obj_addr, 1'b0};

  assign main_hit  = main_valid && main_cs && (main_word == main_tag);
  assign obj_hit   = obj_valid && obj_cs && (obj_addr == obj_tag);
  assign main_pend = main_cs && !main_hit;
  assign obj_pend  = obj_cs && !obj_hit;
  assign frozen    = downloading | loop_rst;
  assign fire      = !frozen && (state == ST_IDLE) && (main_pend || obj_pend);
  assign fill      = !frozen && (state == ST_WAIT) && (cnt == 4'd0);

  // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    pick = GRANT_MAIN;
    if (main_pend && obj_pend)
      pick = (last_grant == GRANT_MAIN) ? GRANT_OBJ : GRANT_MAIN;
    else if (obj_pend)
      pick = GRANT_OBJ;
  end

  // NOTE: cache payload and request tags carry no reset; the valid flags alone decide whether they are used.
  always_ff @(posedge clk) begin
    if (fire) begin
      if (pick == GRANT_MAIN) main_req <= main_word;
      else                    obj_req  <= obj_addr;
    end
    if (fill) begin
      if (grant == GRANT_MAIN) begin
        main_tag  <= main_req;
        main_data <= data_read[15:0];
      end else begin
        obj_tag  <= obj_req;
        obj_data <= data_read;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      grant      <= GRANT_MAIN;
      last_grant <= GRANT_OBJ;
      cnt        <= 4'd0;
      sdram_re   <= 1'b0;
      sdram_addr <= 22'd0;
      main_dout  <= 8'd0;
      obj_dout   <= 32'd0;
      main_ok    <= 1'b0;
      obj_ok     <= 1'b0;
      main_valid <= 1'b0;
      obj_valid  <= 1'b0;
    end else if (frozen) begin
      // sdram_re and sdram_addr hold so the controller never sees a spurious edge.
      state      <= ST_IDLE;
      main_valid <= 1'b0;
      obj_valid  <= 1'b0;
      main_ok    <= 1'b0;
      obj_ok     <= 1'b0;
    end else begin
      main_ok <= main_hit;
      obj_ok  <= obj_hit;
      if (main_hit) main_dout <= main_addr[0] ? main_data[15:8] : main_data[7:0];
      if (obj_hit)  obj_dout  <= obj_data;

      case (state)
        ST_IDLE: begin
          if (fire) begin
            grant    <= pick;
            cnt      <= CNT_LOAD;
            sdram_re <= ~sdram_re;
            state    <= ST_WAIT;
            sdram_addr <= (pick == GRANT_MAIN) ? main_sdram : obj_sdram;
          end
        end
        ST_WAIT: begin
          if (cnt == 4'd0) begin
            if (grant == GRANT_MAIN) main_valid <= 1'b1;
            else                     obj_valid  <= 1'b1;
            last_grant <= grant;
            state      <= ST_IDLE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jtpopeye_sdram_arb.sv
// Directed bench for jtpopeye_sdram_arb: a vector table for single-requester hits and misses,
// plus hand sequences for round-robin, mid-read address change, freeze, cs drop, reset and wrap.
module tb_jtpopeye_sdram_arb;
  localparam int L = 4;

  logic        clk;
  logic        rst_n, downloading, loop_rst;
  logic        main_cs, obj_cs;
  logic [14:0] main_addr;
  logic [12:0] obj_addr;
  logic [7:0]  main_dout;
  logic        main_ok, obj_ok;
  logic [31:0] obj_dout;
  logic        sdram_re;
  logic [21:0] sdram_addr;
  logic [31:0] data_read;

  logic        w_obj_cs;
  logic [12:0] w_obj_addr;
  logic [7:0]  w_main_dout;
  logic        w_main_ok, w_obj_ok, w_sdram_re;
  logic [31:0] w_obj_dout;
  logic [21:0] w_sdram_addr;

  int compared = 0;
  int mismatched = 0;

  // Edge monitor / SDRAM model state
  int          cyc = 0;
  int          n_edges = 0;
  int          edge_cyc [64];
  logic [21:0] edge_addr [64];
  logic [21:0] last_edge_addr = '0;
  logic        re_q = 1'b0;
  int          dcnt = 0;
  bit          data_shown = 0;
  logic [31:0] pend_data = '0;

  jtpopeye_sdram_arb #(.LATENCY(L), .OBJ_OFFSET(22'h4000)) u_dut (
    .clk(clk), .rst_n(rst_n), .downloading(downloading), .loop_rst(loop_rst),
    .main_cs(main_cs), .main_addr(main_addr), .main_dout(main_dout), .main_ok(main_ok),
    .obj_cs(obj_cs), .obj_addr(obj_addr), .obj_dout(obj_dout), .obj_ok(obj_ok),
    .sdram_re(sdram_re), .sdram_addr(sdram_addr), .data_read(data_read)
  );

  jtpopeye_sdram_arb #(.LATENCY(L), .OBJ_OFFSET(22'h3FFFFF)) u_wrap (
    .clk(clk), .rst_n(rst_n), .downloading(1'b0), .loop_rst(1'b0),
    .main_cs(1'b0), .main_addr(15'd0), .main_dout(w_main_dout), .main_ok(w_main_ok),
    .obj_cs(w_obj_cs), .obj_addr(w_obj_addr), .obj_dout(w_obj_dout), .obj_ok(w_obj_ok),
    .sdram_re(w_sdram_re), .sdram_addr(w_sdram_addr), .data_read(32'd0)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] sdram_mem(input logic [21:0] a);
    case (a)
      22'h000001: return 32'h0000BEEF;
      22'h004020: return 32'h12345678;
      22'h00091A: return 32'hCAFE5A3C;
      22'h005FFE: return 32'h89ABCDEF;
      default:    return {10'd0, a} ^ 32'hA5A5A5A5;
    endcase
  endfunction

  // Counts sdram_re edges and presents read data only in the cycle the arbiter must sample it.
  initial begin
    data_read = 32'hDEADDEAD;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (data_shown) begin
        data_read  = 32'hDEADDEAD;
        data_shown = 0;
      end
      if (!rst_n) begin
        re_q = sdram_re;
        dcnt = 0;
      end else begin
        if (dcnt > 0) begin
          dcnt--;
          if (dcnt == 0) begin
            data_read  = pend_data;
            data_shown = 1;
          end
        end
        if (sdram_re !== re_q) begin
          re_q = sdram_re;
          if (n_edges < 64) begin
            edge_cyc[n_edges]  = cyc;
            edge_addr[n_edges] = sdram_addr;
          end
          n_edges++;
          last_edge_addr = sdram_addr;
          pend_data = sdram_mem(sdram_addr);
          dcnt = L - 1;
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    main_cs = 0; obj_cs = 0; w_obj_cs = 0;
    downloading = 0; loop_rst = 0;
    rst_n = 0;
    tick(2);
    rst_n = 1;
  endtask

  task automatic wait_edges(input string name, input int target, input int max);
    int k = 0;
    while (n_edges < target && k < max) begin
      tick(1);
      k++;
    end
    check(name, n_edges, target);
  endtask

  task automatic wait_ok(input bit is_obj, input int max, output int k);
    k = 0;
    while (!(is_obj ? obj_ok : main_ok) && k < max) begin
      tick(1);
      k++;
    end
  endtask

  typedef struct {
    bit          is_obj;
    bit          hit;
    logic [14:0] addr;
    logic [21:0] exp_sdram;
    logic [31:0] exp_dout;
  } vec_t;

  vec_t vecs [10];
  logic [21:0] rr_exp [4];

  initial begin
    int k;
    int e0;
    bit early;
    main_addr = '0; obj_addr = '0; w_obj_addr = '0;

    vecs[0] = '{0, 0, 15'h0003, 22'h000001, 32'h000000BE};
    vecs[1] = '{0, 1, 15'h0002, 22'h000001, 32'h000000EF};
    vecs[2] = '{1, 0, 15'h0010, 22'h004020, 32'h12345678};
    vecs[3] = '{1, 1, 15'h0010, 22'h004020, 32'h12345678};
    vecs[4] = '{0, 0, 15'h1235, 22'h00091A, 32'h0000005A};
    vecs[5] = '{0, 1, 15'h1234, 22'h00091A, 32'h0000003C};
    vecs[6] = '{1, 0, 15'h0FFF, 22'h005FFE, 32'h89ABCDEF};
    vecs[7] = '{0, 0, 15'h0003, 22'h000001, 32'h000000BE};
    vecs[8] = '{0, 0, 15'h7FFF, 22'h003FFF, 32'h0000009A};
    vecs[9] = '{1, 0, 15'h1FFF, 22'h007FFE, 32'hA5A5DA5B};
    rr_exp[0] = 22'h000080; rr_exp[1] = 22'h004040;
    rr_exp[2] = 22'h000180; rr_exp[3] = 22'h004060;

    do_reset();
    check("reset sdram_re", sdram_re, 0);
    check("reset sdram_addr", sdram_addr, 0);
    check("reset main_dout", main_dout, 0);
    check("reset obj_dout", obj_dout, 0);
    check("reset main_ok", main_ok, 0);
    check("reset obj_ok", obj_ok, 0);

    // Single-requester table: misses cost L+2 cycles, hits one.
    for (int i = 0; i < 10; i++) begin
      e0 = n_edges;
      if (vecs[i].is_obj) begin
        obj_cs = 1; obj_addr = vecs[i].addr[12:0];
      end else begin
        main_cs = 1; main_addr = vecs[i].addr;
      end
      wait_ok(vecs[i].is_obj, 20, k);
      check($sformatf("v%0d ok", i), vecs[i].is_obj ? obj_ok : main_ok, 1);
      check($sformatf("v%0d latency", i), k, vecs[i].hit ? 1 : L + 2);
      check($sformatf("v%0d edges", i), n_edges - e0, vecs[i].hit ? 0 : 1);
      if (!vecs[i].hit) check($sformatf("v%0d sdram_addr", i), last_edge_addr, vecs[i].exp_sdram);
      check($sformatf("v%0d dout", i), vecs[i].is_obj ? obj_dout : {24'd0, main_dout}, vecs[i].exp_dout);
      main_cs = 0; obj_cs = 0;
      tick(1);
      check($sformatf("v%0d ok drop", i), vecs[i].is_obj ? obj_ok : main_ok, 0);
      tick(1);
    end

    // Round-robin: both miss from reset; grants alternate main, obj, main, obj.
    do_reset();
    e0 = n_edges;
    main_addr = 15'h0100; obj_addr = 13'h0020; main_cs = 1; obj_cs = 1;
    wait_edges("rr g1", e0 + 1, 4);
    main_addr = 15'h0300;
    wait_edges("rr g2", e0 + 2, 2 * L + 4);
    obj_addr = 13'h0030;
    wait_edges("rr g4", e0 + 4, 3 * L + 8);
    tick(3 * L);
    check("rr edge total", n_edges - e0, 4);
    for (int g = 0; g < 4; g++) begin
      check($sformatf("rr addr %0d", g), edge_addr[e0 + g], rr_exp[g]);
      if (g > 0) check($sformatf("rr spacing %0d", g), edge_cyc[e0 + g] - edge_cyc[e0 + g - 1], L + 1);
    end
    check("rr main_ok", main_ok, 1);
    check("rr main_dout", main_dout, 8'h25);
    check("rr obj_ok", obj_ok, 1);
    check("rr obj_dout", obj_dout, 32'hA5A5E5C5);

    // Address change mid-read: first fill gives no ok, second read follows at L+1 spacing.
    do_reset();
    e0 = n_edges;
    main_cs = 1; main_addr = 15'h0100;
    wait_edges("chg edge1", e0 + 1, 4);
    tick(1);
    main_addr = 15'h0200;
    k = 0; early = 0;
    while (!main_ok && k < 3 * L + 6) begin
      tick(1);
      k++;
      if (main_ok && n_edges < e0 + 2) early = 1;
    end
    check("chg early ok", early, 0);
    check("chg edges", n_edges - e0, 2);
    check("chg addr2", edge_addr[e0 + 1], 22'h000100);
    check("chg spacing", edge_cyc[e0 + 1] - edge_cyc[e0], L + 1);
    check("chg main_ok", main_ok, 1);
    check("chg main_dout", main_dout, 8'hA5);

    // Freeze during a read: no edges, oks drop, caches invalidated and refetched.
    do_reset();
    main_cs = 1; main_addr = 15'h0003;
    wait_ok(0, 20, k);
    obj_cs = 1; obj_addr = 13'h0010;
    wait_ok(1, 20, k);
    check("dl pre obj_ok", obj_ok, 1);
    e0 = n_edges;
    main_addr = 15'h0100;
    wait_edges("dl edge", e0 + 1, 4);
    downloading = 1;
    tick(1);
    check("dl main_ok", main_ok, 0);
    check("dl obj_ok", obj_ok, 0);
    tick(2);
    check("dl no edge", n_edges - e0, 1);
    check("dl addr hold", sdram_addr, 22'h000080);
    downloading = 0;
    wait_edges("dl refetch", e0 + 3, 3 * L + 8);
    check("dl refetch main", edge_addr[e0 + 1], 22'h000080);
    check("dl refetch obj", edge_addr[e0 + 2], 22'h004020);
    tick(L + 2);
    check("dl main_dout", main_dout, 8'h25);
    check("dl obj_ok after", obj_ok, 1);
    check("dl obj_dout", obj_dout, 32'h12345678);
    loop_rst = 1;
    tick(1);
    loop_rst = 0;
    check("lr obj_ok", obj_ok, 0);
    wait_edges("lr refetch", e0 + 5, 3 * L + 8);

    // cs dropped mid-read: cache still fills, no ok until cs returns, then a hit.
    main_cs = 0; obj_cs = 0;
    tick(2 * L);
    e0 = n_edges;
    obj_cs = 1; obj_addr = 13'h0040;
    wait_edges("csd edge", e0 + 1, 4);
    check("csd addr", last_edge_addr, 22'h004080);
    obj_cs = 0;
    early = 0;
    for (int j = 0; j < L + 3; j++) begin
      tick(1);
      if (obj_ok) early = 1;
    end
    check("csd no ok", early, 0);
    obj_cs = 1;
    tick(1);
    check("csd hit ok", obj_ok, 1);
    check("csd hit dout", obj_dout, 32'hA5A5E525);
    check("csd no new edge", n_edges - e0, 1);

    // Reset during a read: no further edge, cache cleared.
    obj_cs = 0; main_cs = 1; main_addr = 15'h0500;
    e0 = n_edges;
    wait_edges("mr edge", e0 + 1, 4);
    do_reset();
    tick(L + 3);
    check("mr sdram_re", sdram_re, 0);
    check("mr no edge", n_edges - e0, 1);
    check("mr main_ok", main_ok, 0);

    // OBJ offset wrap on the second instance.
    w_obj_cs = 1; w_obj_addr = 13'h1FFF;
    tick(1);
    check("wrap sdram_re", w_sdram_re, 1);
    check("wrap sdram_addr", w_sdram_addr, 22'h003FFD);
    w_obj_cs = 0;
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
